// File: rtl/forwarding_scoreboard_if.sv
// forwarding_scoreboard_if: pipeline-control, result and operand-lookup bus of forwarding_scoreboard
//   master: advance, flush, issue_*, res_*, rd_reg, rd_rf_data out; rd_data, rd_stall, stall in
//   slave : mirror of master
interface forwarding_scoreboard_if #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 4,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic                           advance;
  logic                           flush;
  logic [LANES-1:0]               issue_valid;
  logic [LANES*REG_AW-1:0]        issue_reg;
  logic [LANES-1:0]               issue_ready;
  logic [LANES*DATA_W-1:0]        issue_data;
  logic [DEPTH*LANES-1:0]         res_valid;
  logic [DEPTH*LANES*DATA_W-1:0]  res_data;
  logic [NUM_RD*REG_AW-1:0]       rd_reg;
  logic [NUM_RD*DATA_W-1:0]       rd_rf_data;
  logic [NUM_RD*DATA_W-1:0]       rd_data;
  logic [NUM_RD-1:0]              rd_stall;
  logic                           stall;
  modport master (
    output advance, flush, issue_valid, issue_reg, issue_ready, issue_data,
           res_valid, res_data, rd_reg, rd_rf_data,
    input  rd_data, rd_stall, stall
  );
  modport slave (
    input  advance, flush, issue_valid, issue_reg, issue_ready, issue_data,
           res_valid, res_data, rd_reg, rd_rf_data,
    output rd_data, rd_stall, stall
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: per-lane shadow pipeline of in-flight register writes with operand forwarding and hazard stall
//   clk, reset (sync, active-high)
//   bus (slave): advance/flush control, issue_* into stage 0, res_* capture per stage/lane,
//                rd_reg/rd_rf_data lookup in, rd_data/rd_stall/stall out (combinational)
//   FWD_PERF_CNT_EN: adds saturating stall_cnt and fwd_hit_cnt outputs
module forwarding_scoreboard #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 4,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic reset,
  forwarding_scoreboard_if.slave bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] fwd_hit_cnt
`endif
);
  logic [DEPTH-1:0][LANES-1:0]             v, rdy, nr;
  logic [DEPTH-1:0][LANES-1:0][REG_AW-1:0] rg;
  logic [DEPTH-1:0][LANES-1:0][DATA_W-1:0] dt, nd, ld;
  logic [NUM_RD-1:0]                       hit, hr, fwd, pst;
  logic [NUM_RD-1:0][DATA_W-1:0]           hd, od;

  // nr/nd: entry state after this cycle's capture; ld: value a lookup sees (stored if already ready, else bypass)
  always_comb begin
    nr = '0;
    nd = '0;
    ld = '0;
    for (int s = 0; s < DEPTH; s++)
      for (int l = 0; l < LANES; l++) begin
        nr[s][l] = rdy[s][l] | (v[s][l] & bus.res_valid[s*LANES+l]);
        nd[s][l] = (v[s][l] & bus.res_valid[s*LANES+l]) ? bus.res_data[(s*LANES+l)*DATA_W +: DATA_W] : dt[s][l];
        ld[s][l] = rdy[s][l] ? dt[s][l] : nd[s][l];
      end
  end

  // scan oldest to youngest so the last match written is the youngest (lowest stage, highest lane)
  always_comb begin
    hit = '0;
    hr  = '0;
    hd  = '0;
    fwd = '0;
    pst = '0;
    od  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int s = DEPTH-1; s >= 0; s--)
        for (int l = 0; l < LANES; l++)
          if (v[s][l] && rg[s][l] == bus.rd_reg[p*REG_AW +: REG_AW]) begin
            hit[p] = 1'b1;
            hr[p]  = nr[s][l];
            hd[p]  = ld[s][l];
          end
      fwd[p] = hit[p] && hr[p] && bus.rd_reg[p*REG_AW +: REG_AW] != '0;
      pst[p] = hit[p] && !hr[p] && bus.rd_reg[p*REG_AW +: REG_AW] != '0;
      od[p]  = fwd[p] ? hd[p] : bus.rd_rf_data[p*DATA_W +: DATA_W];
    end
  end

  assign bus.rd_data  = od;
  assign bus.rd_stall = pst;
  assign bus.stall    = |pst;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) v <= '0;
    else if (bus.advance) begin
      v   <= {v[DEPTH-2:0], bus.issue_valid};
      rdy <= {nr[DEPTH-2:0], bus.issue_ready};
      rg  <= {rg[DEPTH-2:0], bus.issue_reg};
      dt  <= {nd[DEPTH-2:0], bus.issue_data};
    end else begin
      rdy <= nr;
      dt  <= nd;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [32:0] fsum;
  assign fsum = {1'b0, fwd_hit_cnt} + 33'($countones(fwd));
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      fwd_hit_cnt <= '0;
    end else begin
      if (bus.stall && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
      fwd_hit_cnt <= fsum[32] ? '1 : fsum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb_forwarding_scoreboard: scoreboard bench with a queue-based in-flight write model and randomized traffic
module tb_forwarding_scoreboard;
  localparam int LANES = 2, DEPTH = 3, NUM_RD = 4, DATA_W = 32, REG_AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  forwarding_scoreboard_if #(.LANES(LANES), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .DATA_W(DATA_W), .REG_AW(REG_AW)) b();
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_hit_cnt;
`endif

  forwarding_scoreboard #(.LANES(LANES), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(b)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .fwd_hit_cnt(fwd_hit_cnt)
`endif
  );

  // in-flight writes, youngest first
  typedef struct {
    logic [REG_AW-1:0] r;
    logic              rdy;
    logic [DATA_W-1:0] d;
    int                st;
    int                ln;
  } ent_t;
  typedef struct {
    logic [NUM_RD*DATA_W-1:0] d;
    logic [NUM_RD-1:0]        ps;
    logic                     s;
  } exp_t;

  ent_t  mq[$];
  exp_t  sq[$];
  int    checks = 0, failures = 0;
  longint sc = 0, fc = 0;
  logic  pstall;
  int    pfwd;

  task automatic check(input string n, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, x);
    end
  endtask

  function automatic exp_t predict(output int nf);
    exp_t e;
    logic [REG_AW-1:0] r;
    int idx, k;
    nf = 0;
    e.ps = '0;
    e.d = b.rd_rf_data;
    for (int p = 0; p < NUM_RD; p++) begin
      r = b.rd_reg[p*REG_AW +: REG_AW];
      idx = -1;
      if (r != 0)
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].r == r) begin
            idx = i;
            break;
          end
      if (idx >= 0) begin
        k = mq[idx].st*LANES + mq[idx].ln;
        if (mq[idx].rdy) begin
          e.d[p*DATA_W +: DATA_W] = mq[idx].d;
          nf++;
        end else if (b.res_valid[k]) begin
          e.d[p*DATA_W +: DATA_W] = b.res_data[k*DATA_W +: DATA_W];
          nf++;
        end else e.ps[p] = 1'b1;
      end
    end
    e.s = |e.ps;
    return e;
  endfunction

  task automatic model_step();
    int k;
    if (reset) begin
      mq.delete();
      sc = 0;
      fc = 0;
    end else begin
      sc += longint'(pstall);
      fc += pfwd;
      if (b.flush) mq.delete();
      else begin
        foreach (mq[i]) begin
          k = mq[i].st*LANES + mq[i].ln;
          if (b.res_valid[k]) begin
            mq[i].rdy = 1'b1;
            mq[i].d = b.res_data[k*DATA_W +: DATA_W];
          end
        end
        if (b.advance) begin
          foreach (mq[i]) mq[i].st++;
          for (int i = mq.size()-1; i >= 0; i--)
            if (mq[i].st == DEPTH) mq.delete(i);
          for (int l = 0; l < LANES; l++)
            if (b.issue_valid[l])
              mq.push_front('{r: b.issue_reg[l*REG_AW +: REG_AW], rdy: b.issue_ready[l],
                              d: b.issue_data[l*DATA_W +: DATA_W], st: 0, ln: l});
        end
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    int nf;
    e = predict(nf);
    if (e.s) b.advance = 1'b0;
    sq.push_back(e);
    pstall = e.s;
    pfwd = nf;
    @(negedge clk);
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic clr();
    reset = 1'b0;
    b.advance = 1'b0;
    b.flush = 1'b0;
    b.issue_valid = '0;
    b.issue_ready = '0;
    b.issue_reg = '0;
    b.issue_data = '0;
    b.res_valid = '0;
    b.res_data = '0;
    b.rd_reg = '0;
    b.rd_rf_data = '0;
  endtask

  task automatic iss(input int l, input int r, input bit rd, input logic [DATA_W-1:0] d);
    b.issue_valid[l] = 1'b1;
    b.issue_reg[l*REG_AW +: REG_AW] = REG_AW'(r);
    b.issue_ready[l] = rd;
    b.issue_data[l*DATA_W +: DATA_W] = d;
  endtask

  task automatic res(input int s, input int l, input logic [DATA_W-1:0] d);
    b.res_valid[s*LANES+l] = 1'b1;
    b.res_data[(s*LANES+l)*DATA_W +: DATA_W] = d;
  endtask

  task automatic rd(input int p, input int r, input logic [DATA_W-1:0] f);
    b.rd_reg[p*REG_AW +: REG_AW] = REG_AW'(r);
    b.rd_rf_data[p*DATA_W +: DATA_W] = f;
  endtask

  task automatic ex(input string n, input int p, input logic [DATA_W-1:0] d, input bit st);
    #1;
    check({n, "_data"}, 128'(b.rd_data[p*DATA_W +: DATA_W]), 128'(d));
    check({n, "_stall"}, 128'(b.rd_stall[p]), 128'(st));
  endtask

  always @(negedge clk)
    if (sq.size() != 0) begin
      exp_t e;
      e = sq.pop_front();
      check("sb_rd_data", 128'(b.rd_data), 128'(e.d));
      check("sb_rd_stall", 128'(b.rd_stall), 128'(e.ps));
      check("sb_stall", 128'(b.stall), 128'(e.s));
    end

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // reset state
    clr(); reset = 1'b1; rd(0, 5, 32'hAA); ex("reset_rf", 0, 32'hAA, 0); tick();
    // same-cycle bypass from stage 0
    clr(); iss(0, 3, 0, 0); b.advance = 1'b1; tick();
    clr(); res(0, 0, 32'h10); rd(0, 3, 32'h55); ex("bypass", 0, 32'h10, 0); tick();
    // load-use stall, hold, then result in stage 1
    clr(); iss(0, 4, 0, 0); b.advance = 1'b1; tick();
    clr(); rd(1, 4, 32'h99); ex("load_stall", 1, 32'h99, 1); tick();
    clr(); rd(1, 4, 32'h99); ex("load_hold", 1, 32'h99, 1); tick();
    clr(); b.advance = 1'b1; tick();
    clr(); res(1, 0, 32'h44); rd(1, 4, 32'h99); ex("load_res", 1, 32'h44, 0); tick();
    // youngest lane, then youngest stage
    clr(); iss(0, 7, 1, 32'h1); iss(1, 7, 1, 32'h2); b.advance = 1'b1; tick();
    clr(); rd(2, 7, 0); ex("lane_young", 2, 32'h2, 0); iss(0, 7, 1, 32'h3); b.advance = 1'b1; tick();
    clr(); rd(2, 7, 0); ex("stage_young", 2, 32'h3, 0); tick();
    // flush beats issue
    clr(); b.flush = 1'b1; iss(0, 9, 1, 32'h5); b.advance = 1'b1; tick();
    clr(); rd(0, 7, 32'hBB); rd(1, 9, 32'hCC); ex("flush_r7", 0, 32'hBB, 0); ex("flush_r9", 1, 32'hCC, 0); tick();
    // r0 never forwards
    clr(); iss(0, 0, 1, 32'h77); iss(1, 0, 0, 0); b.advance = 1'b1; tick();
    clr(); rd(3, 0, 32'h66); ex("r0", 3, 32'h66, 0); tick();
    // three stall cycles from reset
    clr(); reset = 1'b1; tick();
    clr(); iss(1, 12, 0, 0); b.advance = 1'b1; tick();
    repeat (3) begin
      clr(); rd(0, 12, 32'h12); ex("perf_stall", 0, 32'h12, 1); tick();
    end
`ifdef FWD_PERF_CNT_EN
    check("stall_cnt_3", 128'(stall_cnt), 128'(3));
`endif
    // random traffic
    for (int n = 0; n < 500; n++) begin
      clr();
      reset = ($urandom_range(0, 99) == 0);
      b.flush = ($urandom_range(0, 19) == 0);
      b.advance = 1'($urandom_range(0, 1));
      for (int l = 0; l < LANES; l++)
        if ($urandom_range(0, 2) != 0) iss(l, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom);
      for (int s = 0; s < DEPTH; s++)
        for (int l = 0; l < LANES; l++)
          if ($urandom_range(0, 3) == 0) res(s, l, $urandom);
      for (int p = 0; p < NUM_RD; p++) rd(p, $urandom_range(0, 7), $urandom);
      tick();
    end
    clr();
    #1;
    check("queue_drain", 128'(sq.size()), 128'(0));
`ifdef FWD_PERF_CNT_EN
    check("stall_cnt", 128'(stall_cnt), 128'(sc));
    check("fwd_hit_cnt", 128'(fwd_hit_cnt), 128'(fc));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
